// File: rtl/elevator_request_queue.sv
// Elevator call queue: latches floor-button presses and picks the next target floor
// using a sweep (up/down) policy, handing w/req_valid to the elevator FSM.
module elevator_request_queue (
    input  logic       clk,
    input  logic       clr_,
    input  logic [3:0] req_btn,
    input  logic [2:0] cur_floor,
    input  logic       arrived,
    output logic [2:0] w,
    output logic       req_valid,
    output logic       dir_up,
    output logic [3:0] pending,
    output logic [1:0] state_dbg
);

    // Handshake: req_valid qualifies w; there is no ready. The elevator FSM consumes
    // w while req_valid is high and reports completion with a one-cycle arrived pulse.

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] btn_q;

    logic [1:0] cur_idx;
    logic [2:0] cur_code;
    logic [3:0] cur_oh;
    logic [3:0] btn_edge;
    logic [3:0] clr_mask;
    logic [3:0] pending_nxt;
    logic [3:0] ge_mask;
    logic [3:0] le_mask;
    logic [3:0] up_cand;
    logic [3:0] dn_cand;
    logic [1:0] up_idx;
    logic [1:0] dn_idx;
    logic       cur_pending;
    logic       near_up;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        casez (v)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] high_idx(input logic [3:0] v);
        logic [1:0] r;
        casez (v)
            4'b1???: r = 2'd3;
            4'b01??: r = 2'd2;
            4'b001?: r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] idx_to_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

    // Out-of-range floor codes are folded onto the ground floor.
    always_comb begin
        cur_idx = 2'd0;
        case (cur_floor)
            3'd2:    cur_idx = 2'd1;
            3'd3:    cur_idx = 2'd2;
            3'd4:    cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
    end

    assign cur_code    = idx_to_code(cur_idx);
    assign cur_oh      = 4'b0001 << cur_idx;
    assign btn_edge    = req_btn & ~btn_q;
    assign clr_mask    = arrived ? cur_oh : 4'b0000;
    assign pending_nxt = (pending | btn_edge) & ~clr_mask;

    assign ge_mask     = 4'b1111 << cur_idx;
    assign le_mask     = 4'b1111 >> (2'd3 - cur_idx);
    assign up_cand     = pending & ge_mask;
    assign dn_cand     = pending & le_mask;
    assign up_idx      = low_idx(up_cand);
    assign dn_idx      = high_idx(dn_cand);
    assign cur_pending = |(pending & cur_oh);

    // Only used from IDLE when the current floor is not pending, so up_idx > cur_idx
    // and dn_idx < cur_idx; a distance tie goes to the upper floor.
    assign near_up = (|up_cand) &&
                     (!(|dn_cand) || ((up_idx - cur_idx) <= (cur_idx - dn_idx)));

    assign state_dbg = state;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state     <= IDLE;
            btn_q     <= 4'b0000;
            pending   <= 4'b0000;
            dir_up    <= 1'b1;
            w         <= 3'd1;
            req_valid <= 1'b0;
        end else begin
            btn_q   <= req_btn;
            pending <= pending_nxt;

            if (pending == 4'b0000) begin
                state     <= IDLE;
                w         <= cur_code;
                req_valid <= 1'b0;
            end else begin
                req_valid <= 1'b1;
                case (state)
                    IDLE: begin
                        if (cur_pending) begin
                            state <= dir_up ? SERVE_UP : SERVE_DOWN;
                            w     <= cur_code;
                        end else if (near_up) begin
                            state  <= SERVE_UP;
                            dir_up <= 1'b1;
                            w      <= idx_to_code(up_idx);
                        end else begin
                            state  <= SERVE_DOWN;
                            dir_up <= 1'b0;
                            w      <= idx_to_code(dn_idx);
                        end
                    end
                    SERVE_UP: begin
                        if (|up_cand) begin
                            w <= idx_to_code(up_idx);
                        end else begin
                            state  <= SERVE_DOWN;
                            dir_up <= 1'b0;
                            w      <= idx_to_code(dn_idx);
                        end
                    end
                    SERVE_DOWN: begin
                        if (|dn_cand) begin
                            w <= idx_to_code(dn_idx);
                        end else begin
                            state  <= SERVE_UP;
                            dir_up <= 1'b1;
                            w      <= idx_to_code(up_idx);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        w     <= cur_code;
                    end
                endcase
            end
        end
    end

endmodule
